// File: rtl/denormalization.sv
// denormalization: iterative STEP-bit-per-cycle right-shift denormalizer; sticky collection enabled by DENORM_STICKY_EN
module denormalization #(
  parameter int STEP = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic        i_mode,
  input  logic [52:0] i_res53,
  input  logic [5:0]  i_sh52,
  input  logic [4:0]  i_sh29,
  input  logic [4:0]  i_sh24,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [52:0] o_res53,
  output logic [1:0]  o_sticky
);
  localparam logic [5:0] STEP_HI = 6'(STEP);
  localparam logic [4:0] STEP_LO = 5'(STEP);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t r_state, w_next;
  logic        r_mode;
  logic [52:0] r_res, w_res_n;
  logic [5:0]  r_rem_hi, w_sh_hi, w_amt_hi, w_rem_hi_n;
  logic [4:0]  r_rem_lo, w_sh_lo, w_amt_lo, w_rem_lo_n;
  logic        w_acc, w_zero;
  assign o_valid = r_state == DONE;
  assign o_ready = (r_state == IDLE) | ((r_state == DONE) & i_ready);
  assign o_res53 = r_res;
  always_comb begin
    w_sh_hi    = i_mode ? (i_sh52 > 6'd53 ? 6'd53 : i_sh52) : {1'b0, (i_sh29 > 5'd29 ? 5'd29 : i_sh29)};
    w_sh_lo    = i_mode ? 5'd0 : (i_sh24 > 5'd24 ? 5'd24 : i_sh24);
    w_zero     = (w_sh_hi == 6'd0) && (w_sh_lo == 5'd0);
    w_acc      = i_valid & o_ready;
    w_amt_hi   = r_rem_hi > STEP_HI ? STEP_HI : r_rem_hi;
    w_amt_lo   = r_rem_lo > STEP_LO ? STEP_LO : r_rem_lo;
    w_rem_hi_n = r_rem_hi - w_amt_hi;
    w_rem_lo_n = r_rem_lo - w_amt_lo;
    // lanes are shifted independently so no bit crosses the 24/29 boundary in dual mode
    w_res_n    = r_mode ? r_res >> w_amt_hi : {r_res[52:24] >> w_amt_hi, r_res[23:0] >> w_amt_lo};
    w_next     = r_state;
    if (w_acc)
      w_next = w_zero ? DONE : SHIFT;
    else if (r_state == SHIFT)
      w_next = (w_rem_hi_n == 6'd0 && w_rem_lo_n == 5'd0) ? DONE : SHIFT;
    else if (r_state == DONE)
      w_next = i_ready ? IDLE : DONE;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_mode   <= 1'b0;
      r_res    <= '0;
      r_rem_hi <= '0;
      r_rem_lo <= '0;
    end else begin
      r_state <= w_next;
      if (w_acc) begin
        r_mode   <= i_mode;
        r_res    <= i_res53;
        r_rem_hi <= w_sh_hi;
        r_rem_lo <= w_sh_lo;
      end else if (r_state == SHIFT) begin
        r_res    <= w_res_n;
        r_rem_hi <= w_rem_hi_n;
        r_rem_lo <= w_rem_lo_n;
      end
    end
  end
`ifdef DENORM_STICKY_EN
  logic [1:0] r_st;
  logic       w_out_hi, w_out_lo;
  always_comb begin
    w_out_hi = r_mode ? (|(r_res & ~({53{1'b1}} << w_amt_hi))) : (|(r_res[52:24] & ~({29{1'b1}} << w_amt_hi)));
    w_out_lo = !r_mode && (|(r_res[23:0] & ~({24{1'b1}} << w_amt_lo)));
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_st <= 2'b00;
    else if (w_acc)
      r_st <= 2'b00;
    else if (r_state == SHIFT)
      r_st <= r_st | {w_out_hi, w_out_lo};
  end
  assign o_sticky = r_st;
`else
  assign o_sticky = 2'b00;
`endif
endmodule

// File: tb/tb_denormalization.sv
// tb_denormalization: randomized scoreboard bench for denormalization against an arithmetic reference model
module tb_denormalization;
  localparam int STEP = 8;
  typedef struct {
    logic [52:0] res;
    logic [1:0]  st;
    int          n;
    int          acc;
  } exp_t;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        i_valid, o_ready, i_mode, o_valid, i_ready;
  logic [52:0] i_res53, o_res53;
  logic [5:0]  i_sh52;
  logic [4:0]  i_sh29, i_sh24;
  logic [1:0]  o_sticky;
  exp_t        q[$];
  int          cyc = 0, n_cmp = 0, n_bad = 0;
  bit          seen = 1'b0;
  logic [1:0]  rdy_fix = 2'd2;

  denormalization #(.STEP(STEP)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_mode(i_mode), .i_res53(i_res53), .i_sh52(i_sh52), .i_sh29(i_sh29), .i_sh24(i_sh24),
    .o_valid(o_valid), .i_ready(i_ready), .o_res53(o_res53), .o_sticky(o_sticky)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic exp_t model(logic m, logic [52:0] d, logic [5:0] s52, logic [4:0] s29, logic [4:0] s24);
    exp_t e;
    logic [63:0] u, l;
    int su, sl, nu, nl;
    if (m) begin
      su = int'(s52) > 53 ? 53 : int'(s52);
      sl = 0;
      u = {11'b0, d};
      l = 64'd0;
      e.res = 53'(u >> su);
    end else begin
      su = int'(s29) > 29 ? 29 : int'(s29);
      sl = int'(s24) > 24 ? 24 : int'(s24);
      u = {35'b0, d[52:24]};
      l = {40'b0, d[23:0]};
      e.res = {29'(u >> su), 24'(l >> sl)};
    end
    e.st = {|(u & ((64'd1 << su) - 64'd1)), |(l & ((64'd1 << sl) - 64'd1))};
`ifndef DENORM_STICKY_EN
    e.st = 2'b00;
`endif
    nu = (su + STEP - 1) / STEP;
    nl = (sl + STEP - 1) / STEP;
    e.n = nu > nl ? nu : nl;
    e.acc = 0;
    return e;
  endfunction

  task automatic send(input logic m, input logic [52:0] d, input logic [5:0] s52, input logic [4:0] s29, input logic [4:0] s24);
    exp_t e;
    bit ok;
    e = model(m, d, s52, s29, s24);
    ok = 1'b0;
    i_valid = 1'b1; i_mode = m; i_res53 = d; i_sh52 = s52; i_sh29 = s29; i_sh24 = s24;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      if (o_ready) begin
        e.acc = cyc + 1;
        q.push_back(e);
        ok = 1'b1;
      end
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: o_ready stayed %0b, required 1", o_ready);
    end
    @(posedge clk); #1;
    i_valid = 1'b0;
    i_mode = 1'($urandom);
    i_res53 = 53'({$urandom, $urandom});
    i_sh52 = 6'($urandom); i_sh29 = 5'($urandom); i_sh24 = 5'($urandom);
  endtask

  task automatic drain();
    for (int t = 0; t < 2000 && q.size() != 0; t++) @(posedge clk);
    #1;
    chk("drain_queue_empty", 64'(q.size()), 64'd0);
  endtask

  initial forever begin
    @(posedge clk); #2;
    i_ready = rdy_fix == 2'd0 ? ($urandom_range(0, 3) != 0) : (rdy_fix == 2'd2);
  end

  initial forever begin
    @(negedge clk);
    if (rst_n && o_valid) begin
      if (q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_valid: o_valid=1 with res %0h, required no result", o_res53);
      end else begin
        if (!seen) begin
          chk("latency", 64'(cyc), 64'(q[0].acc + q[0].n));
          seen = 1'b1;
        end
        chk("res53", 64'(o_res53), 64'(q[0].res));
        chk("sticky", 64'(o_sticky), 64'(q[0].st));
        chk("ready_in_done", 64'(o_ready), 64'(i_ready));
        if (i_ready) begin
          void'(q.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  initial begin
    i_valid = 1'b0; i_ready = 1'b1; i_mode = 1'b0; i_res53 = '0;
    i_sh52 = '0; i_sh29 = '0; i_sh24 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_ready", 64'(o_ready), 64'd1);
    chk("rst_res", 64'(o_res53), 64'd0);
    chk("rst_sticky", 64'(o_sticky), 64'd0);
    rst_n = 1'b1;
    send(1'b1, 53'h10000000000000, 6'd4, 5'd0, 5'd0);
    send(1'b0, {29'h10000000, 24'h000003}, 6'd0, 5'd8, 5'd1);
    send(1'b1, 53'h1, 6'd63, 5'd0, 5'd0);
    send(1'b0, {29'h1ABCDEF1, 24'h123456}, 6'd0, 5'd29, 5'd0);
    send(1'b0, {29'h1FFFFFFF, 24'hFFFFFF}, 6'd0, 5'd31, 5'd31);
    drain();
    rdy_fix = 2'd1;
    send(1'b1, 53'h1F0F0F0F0F0F0F, 6'd20, 5'd0, 5'd0);
    for (int t = 0; t < 50 && !o_valid; t++) @(negedge clk);
    repeat (3) begin
      @(negedge clk);
      chk("bp_ready_low", 64'(o_ready), 64'd0);
      chk("bp_valid_held", 64'(o_valid), 64'd1);
    end
    @(posedge clk); #1;
    rdy_fix = 2'd2;
    send(1'b1, 53'h0ABCDE12345678, 6'd0, 5'd0, 5'd0);
    drain();
    send(1'b1, 53'h1234567890ABCD, 6'd40, 5'd0, 5'd0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(o_valid), 64'd0);
    chk("midrst_res", 64'(o_res53), 64'd0);
    chk("midrst_ready", 64'(o_ready), 64'd1);
    q.delete();
    seen = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(1'b1, 53'h1FFFFFFFFFFFFF, 6'd13, 5'd0, 5'd0);
    drain();
    rdy_fix = 2'd0;
    repeat (150) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      send(1'($urandom), 53'({$urandom, $urandom}), 6'($urandom_range(0, 63)),
           5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end
    rdy_fix = 2'd2;
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
